// File: rtl/led_status_ctrl.sv
// led_status_ctrl
// Registered status-LED driver for the mode-indicator bank.
//   IDLE    : mode 0 mirrors the switches, modes 1..MODE_N-1 light one
//             one-hot LED, out-of-range modes leave the bank dark.
//   ERR_ON  : all LEDs lit  (error blink, first half-period)
//   ERR_OFF : all LEDs dark (error blink, second half-period)
// An err_pulse starts (or restarts) a self-timed blink sequence of
// BLINK_CNT full on/off blinks (0 = blink until err_clear).
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   mode_state current mode from the mode FSM          [MODE_W]
//   sw         mode switches, mirrored in mode 0        [SW_W]
//   err_pulse  one-cycle error event strobe
//   err_clear  aborts the blink sequence
//   dim_level  PWM brightness for the IDLE display [4] (LED_DIM_EN only)
//   mode_led   registered LED drive                     [LED_W]
//   err_busy   registered, high while blinking
//
// Optional feature macro: LED_DIM_EN (adds dim_level and a 4-bit PWM
// counter that gates the IDLE display; the blink display is never dimmed).
module led_status_ctrl #(
    parameter int LED_W       = 8,
    parameter int SW_W        = 5,
    parameter int MODE_W      = 3,
    parameter int MODE_N      = 6,
    parameter int HALF_PERIOD = 50_000_000,
    parameter int BLINK_CNT   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [MODE_W-1:0] mode_state,
    input  logic [SW_W-1:0]   sw,
    input  logic              err_pulse,
    input  logic              err_clear,
`ifdef LED_DIM_EN
    input  logic [3:0]        dim_level,
`endif
    output logic [LED_W-1:0]  mode_led,
    output logic              err_busy
);

    localparam int PW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam int BW = (BLINK_CNT > 1) ? $clog2(BLINK_CNT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ERR_ON  = 2'd1,
        ERR_OFF = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [PW-1:0]    presc_reg, presc_next;
    logic [BW-1:0]    blink_reg, blink_next, blink_inc;
    logic             tick;
    logic [LED_W-1:0] onehot;
    logic [LED_W-1:0] idle_disp;
    logic [LED_W-1:0] idle_gated;
    logic [LED_W-1:0] led_next;

`ifdef LED_DIM_EN
    logic [3:0] pwm_reg;
`endif

    // One-hot decode: LED gi lights for mode gi+1. LEDs beyond the last
    // valid mode are tied off so no truncated compare can alias onto them.
    generate
        for (genvar gi = 0; gi < LED_W; gi++) begin : g_onehot
            if (gi < MODE_N - 1) begin : g_used
                assign onehot[gi] = (32'(mode_state) == gi + 1);
            end else begin : g_unused
                assign onehot[gi] = 1'b0;
            end
        end
    endgenerate

    // Out-of-range modes fall out naturally: no onehot bit matches.
    assign idle_disp = (mode_state == '0) ? LED_W'(sw) : onehot;

`ifdef LED_DIM_EN
    assign idle_gated = (pwm_reg < dim_level) ? idle_disp : '0;
`else
    assign idle_gated = idle_disp;
`endif

    assign tick      = (presc_reg == PW'(HALF_PERIOD - 1));
    assign blink_inc = blink_reg + BW'(1);

    always_comb begin
        state_next = state_reg;
        presc_next = presc_reg;
        blink_next = blink_reg;
        if (err_clear) begin
            state_next = IDLE;
            presc_next = '0;
            blink_next = '0;
        end else if (err_pulse) begin
            state_next = ERR_ON;
            presc_next = '0;
            blink_next = '0;
        end else begin
            case (state_reg)
                ERR_ON: begin
                    if (tick) begin
                        state_next = ERR_OFF;
                        presc_next = '0;
                    end else begin
                        presc_next = presc_reg + PW'(1);
                    end
                end
                ERR_OFF: begin
                    if (tick) begin
                        presc_next = '0;
                        if (BLINK_CNT != 0 && blink_inc == BW'(BLINK_CNT)) begin
                            state_next = IDLE;
                            blink_next = '0;
                        end else begin
                            state_next = ERR_ON;
                            // Endless mode never needs the count.
                            blink_next = (BLINK_CNT == 0) ? '0 : blink_inc;
                        end
                    end else begin
                        presc_next = presc_reg + PW'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                    presc_next = '0;
                    blink_next = '0;
                end
            endcase
        end
    end

    // Display follows the state being entered, so the LED register shows
    // the effect of this edge's inputs right after the edge.
    always_comb begin
        case (state_next)
            ERR_ON:  led_next = '1;
            ERR_OFF: led_next = '0;
            default: led_next = idle_gated;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            presc_reg <= '0;
            blink_reg <= '0;
            mode_led  <= '0;
            err_busy  <= 1'b0;
`ifdef LED_DIM_EN
            pwm_reg   <= '0;
`endif
        end else begin
            state_reg <= state_next;
            presc_reg <= presc_next;
            blink_reg <= blink_next;
            mode_led  <= led_next;
            err_busy  <= (state_next != IDLE);
`ifdef LED_DIM_EN
            pwm_reg   <= pwm_reg + 4'd1;
`endif
        end
    end

endmodule

// File: tb/tb_led_status_ctrl.sv
module tb_led_status_ctrl;

    localparam int LED_W  = 8;
    localparam int SW_W   = 5;
    localparam int MODE_W = 3;
    localparam int MODE_N = 6;
    localparam int HP     = 4;
    localparam int BC     = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [MODE_W-1:0] mode_state;
    logic [SW_W-1:0]   sw;
    logic              err_pulse;
    logic              err_clear;
`ifdef LED_DIM_EN
    logic [3:0]        dim_level;
`endif
    logic [LED_W-1:0]  mode_led;
    logic              err_busy;

    led_status_ctrl #(
        .LED_W(LED_W), .SW_W(SW_W), .MODE_W(MODE_W), .MODE_N(MODE_N),
        .HALF_PERIOD(HP), .BLINK_CNT(BC)
    ) dut (
        .clk(clk), .rst(rst), .mode_state(mode_state), .sw(sw),
        .err_pulse(err_pulse), .err_clear(err_clear),
`ifdef LED_DIM_EN
        .dim_level(dim_level),
`endif
        .mode_led(mode_led), .err_busy(err_busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: a sequence is "elapsed" cycles old; lit during
    // even-numbered half-periods, ends after 2*BC*HP cycles.
    bit               m_active;
    int               m_elapsed;
    int               m_pwm;
    logic [LED_W-1:0] m_led;
    logic             m_busy;

    function automatic logic [LED_W-1:0] idle_model(int ms, int swv, int pwm, int dim);
        logic [LED_W-1:0] v;
        if (ms == 0)           v = LED_W'(swv);
        else if (ms < MODE_N)  v = LED_W'(1 << (ms - 1));
        else                   v = '0;
`ifdef LED_DIM_EN
        if (!(pwm < dim)) v = '0;
`endif
        return v;
    endfunction

    task automatic model_update();
        int dim;
        dim = 15;
`ifdef LED_DIM_EN
        dim = int'(dim_level);
`endif
        if (rst) begin
            m_active = 0; m_elapsed = 0; m_pwm = 0;
            m_led = '0; m_busy = 1'b0;
        end else begin
            if (err_clear) m_active = 0;
            else if (err_pulse) begin m_active = 1; m_elapsed = 0; end
            else if (m_active) begin
                m_elapsed++;
                if (BC != 0 && m_elapsed >= 2 * BC * HP) m_active = 0;
            end
            if (m_active) begin
                m_busy = 1'b1;
                m_led  = ((m_elapsed / HP) % 2 == 0) ? '1 : '0;
            end else begin
                m_busy = 1'b0;
                m_led  = idle_model(int'(mode_state), int'(sw), m_pwm, dim);
            end
            m_pwm = (m_pwm + 1) % 16;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(logic r, int ms, int swv, logic p, logic c);
        rst = r; mode_state = MODE_W'(ms); sw = SW_W'(swv);
        err_pulse = p; err_clear = c;
    endtask

    typedef struct {
        logic             rst;
        int               ms;
        int               swv;
        logic [LED_W-1:0] exp_led;
        logic             exp_busy;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int busy_cnt;
        logic [LED_W-1:0] pat;
        vecs[0]  = '{1'b1, 0, 5'h15, 8'h00, 1'b0};
        vecs[1]  = '{1'b1, 0, 5'h15, 8'h00, 1'b0};
        vecs[2]  = '{1'b0, 0, 5'h15, 8'h15, 1'b0};
        vecs[3]  = '{1'b0, 1, 5'h15, 8'h01, 1'b0};
        vecs[4]  = '{1'b0, 2, 5'h15, 8'h02, 1'b0};
        vecs[5]  = '{1'b0, 3, 5'h15, 8'h04, 1'b0};
        vecs[6]  = '{1'b0, 4, 5'h15, 8'h08, 1'b0};
        vecs[7]  = '{1'b0, 5, 5'h15, 8'h10, 1'b0};
        vecs[8]  = '{1'b0, 6, 5'h15, 8'h00, 1'b0};
        vecs[9]  = '{1'b0, 7, 5'h15, 8'h00, 1'b0};
        vecs[10] = '{1'b0, 0, 5'h1f, 8'h1f, 1'b0};

`ifdef LED_DIM_EN
        dim_level = 4'd15;
`endif
        drive(1'b1, 0, 5'h15, 1'b0, 1'b0);
        m_active = 0; m_elapsed = 0; m_pwm = 0; m_led = '0; m_busy = 1'b0;

        // Table: reset and mode sweep
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].rst, vecs[i].ms, vecs[i].swv, 1'b0, 1'b0);
            step();
`ifdef LED_DIM_EN
            check($sformatf("vec%0d_led", i), 32'(mode_led), 32'(m_led));
`else
            check($sformatf("vec%0d_led", i), 32'(mode_led), 32'(vecs[i].exp_led));
`endif
            check($sformatf("vec%0d_busy", i), 32'(err_busy), 32'(vecs[i].exp_busy));
        end

        // Single pulse: FFx4 00x4 FFx4 00x4 then idle
        drive(1'b0, 2, 0, 1'b1, 1'b0);
        busy_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            err_pulse = 1'b0;
            pat = (k < 4 || (k >= 8 && k < 12)) ? 8'hff : 8'h00;
            check($sformatf("seqA_led%0d", k), 32'(mode_led), 32'(pat));
            if (err_busy) busy_cnt++;
        end
        check("seqA_busycnt", 32'(busy_cnt), 32'd16);
        step();
        check("seqA_idle_busy", 32'(err_busy), 32'd0);
        check("seqA_idle_led", 32'(mode_led), 32'(m_led));

        // Restart during the second ERR_OFF
        err_pulse = 1'b1;
        for (int k = 0; k < 13; k++) begin
            step();
            err_pulse = 1'b0;
        end
        check("seqB_pre_led", 32'(mode_led), 32'h00);
        err_pulse = 1'b1;
        busy_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            err_pulse = 1'b0;
            pat = (k < 4 || (k >= 8 && k < 12)) ? 8'hff : 8'h00;
            check($sformatf("seqB_led%0d", k), 32'(mode_led), 32'(pat));
            if (err_busy) busy_cnt++;
        end
        check("seqB_busycnt", 32'(busy_cnt), 32'd16);
        step();
        check("seqB_idle_busy", 32'(err_busy), 32'd0);

        // err_clear during ERR_ON
        drive(1'b0, 3, 0, 1'b1, 1'b0);
        step();
        err_pulse = 1'b0;
        step();
        check("seqC_on_led", 32'(mode_led), 32'hff);
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        check("seqC_clr_busy", 32'(err_busy), 32'd0);
`ifdef LED_DIM_EN
        check("seqC_clr_led", 32'(mode_led), 32'(m_led));
`else
        check("seqC_clr_led", 32'(mode_led), 32'h04);
`endif
        // pulse and clear together
        err_pulse = 1'b1; err_clear = 1'b1;
        step();
        err_pulse = 1'b0; err_clear = 1'b0;
        check("seqC_both_busy", 32'(err_busy), 32'd0);
        check("seqC_both_led", 32'(mode_led), 32'(m_led));

        // Held pulse keeps LEDs on
        err_pulse = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            check($sformatf("held_led%0d", k), 32'(mode_led), 32'hff);
        end
        err_pulse = 1'b0;
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;

`ifdef LED_DIM_EN
        // Dimming: bit0 high 4 of 16 cycles; blink undimmed
        dim_level = 4'd4;
        mode_state = 3'd1;
        step();
        busy_cnt = 0;
        for (int k = 0; k < 32; k++) begin
            step();
            if (mode_led[0]) busy_cnt++;
        end
        check("dim_duty", 32'(busy_cnt), 32'd8);
        err_pulse = 1'b1;
        step();
        err_pulse = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step();
            check($sformatf("dim_on%0d", k), 32'(mode_led), 32'hff);
        end
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
`endif

        // Randomized against the model
        for (int k = 0; k < 3000; k++) begin
            rst        = ($urandom_range(0, 299) == 0);
            mode_state = MODE_W'($urandom);
            sw         = SW_W'($urandom);
            err_pulse  = ($urandom_range(0, 39) == 0);
            err_clear  = ($urandom_range(0, 79) == 0);
`ifdef LED_DIM_EN
            dim_level  = 4'($urandom);
`endif
            step();
            if (mode_led !== m_led || err_busy !== m_busy) begin
                check($sformatf("rand%0d_led", k), 32'(mode_led), 32'(m_led));
                check($sformatf("rand%0d_busy", k), 32'(err_busy), 32'(m_busy));
            end else begin
                checks++;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
